// File: rtl/dfu_bank_rd_sched_pkg.sv
// Shared types, widths and helpers for the DFU bank read scheduler.
package dfu_bank_rd_sched_pkg;

    function automatic int clog2_fn(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < 32'(value)) width = i + 1;
        end
        return width;
    endfunction

    localparam int no_of_sram_banks = 8;
    localparam int no_of_sel_ln     = clog2_fn(no_of_sram_banks);
    localparam int ADDR_W           = 10;
    localparam int CNT_W            = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dfu_state_e;

    function automatic logic [no_of_sram_banks-1:0] onehot_fn(input logic [no_of_sel_ln-1:0] idx);
        logic [no_of_sram_banks-1:0] one;
        one = {{(no_of_sram_banks-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/dfu_bank_rd_sched_if.sv
// Config/start, backpressure and SRAM/mux-side signals of the read scheduler.
interface dfu_bank_rd_sched_if;
    import dfu_bank_rd_sched_pkg::*;

    logic                        start;
    logic [ADDR_W-1:0]           cfg_base_addr;
    logic [CNT_W-1:0]            cfg_num_words;
    logic [no_of_sel_ln:0]       cfg_num_banks;
    logic                        sys_ready;
    logic [no_of_sram_banks-1:0] sram_rd_en;
    logic [ADDR_W-1:0]           sram_rd_addr;
    logic [no_of_sel_ln-1:0]     mux_sel;
    logic                        ack_start_sys;
    logic                        busy;
    logic                        done;

    modport master (
        output start, cfg_base_addr, cfg_num_words, cfg_num_banks, sys_ready,
        input  sram_rd_en, sram_rd_addr, mux_sel, ack_start_sys, busy, done
    );

    modport slave (
        input  start, cfg_base_addr, cfg_num_words, cfg_num_banks, sys_ready,
        output sram_rd_en, sram_rd_addr, mux_sel, ack_start_sys, busy, done
    );

endinterface

// File: rtl/dfu_rd_addr_gen.sv
// Latched sweep config plus bank-fastest bank/word counters and the read address.
module dfu_rd_addr_gen
    import dfu_bank_rd_sched_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    adv,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [CNT_W-1:0]        num_words,
    input  logic [no_of_sel_ln:0]   num_banks,
    output logic [no_of_sel_ln-1:0] bank_cnt,
    output logic [ADDR_W-1:0]       rd_addr,
    output logic                    last_issue
);
    localparam logic [no_of_sel_ln:0] bank_one = {{no_of_sel_ln{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      word_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0]       base_r;
    logic [CNT_W-1:0]        num_words_r;
    logic [no_of_sel_ln:0]   num_banks_r;
    logic [no_of_sel_ln-1:0] bank_cnt_r;
    logic [CNT_W-1:0]        word_cnt_r;
    logic                    bank_last_s;
    logic                    word_last_s;

    // End-of-row / end-of-window detection and the wrapping address add
    always_comb begin
        bank_last_s = ({1'b0, bank_cnt_r} == (num_banks_r - bank_one));
        word_last_s = (word_cnt_r == (num_words_r - word_one));
        last_issue  = bank_last_s && word_last_s;
        rd_addr     = base_r + word_cnt_r[ADDR_W-1:0];
        bank_cnt    = bank_cnt_r;
    end

    // Config capture at accepted start and nested counter advance per issue
    always_ff @(posedge clk) begin
        if (!rst) begin
            base_r      <= {ADDR_W{1'b0}};
            num_words_r <= {CNT_W{1'b0}};
            num_banks_r <= {(no_of_sel_ln+1){1'b0}};
            bank_cnt_r  <= {no_of_sel_ln{1'b0}};
            word_cnt_r  <= {CNT_W{1'b0}};
        end else if (load) begin
            base_r      <= base_addr;
            num_words_r <= num_words;
            num_banks_r <= num_banks;
            bank_cnt_r  <= {no_of_sel_ln{1'b0}};
            word_cnt_r  <= {CNT_W{1'b0}};
        end else if (adv) begin
            if (bank_last_s) begin
                bank_cnt_r <= {no_of_sel_ln{1'b0}};
                word_cnt_r <= word_cnt_r + word_one;
            end else begin
                bank_cnt_r <= bank_cnt_r + {{(no_of_sel_ln-1){1'b0}}, 1'b1};
                word_cnt_r <= word_cnt_r;
            end
        end else begin
            bank_cnt_r <= bank_cnt_r;
            word_cnt_r <= word_cnt_r;
        end
    end

endmodule

// File: rtl/dfu_bank_rd_sched.sv
// DFU read scheduler: sweeps a word window across the active banks and drives
// the output mux select/capture strobe one cycle behind each bank read.
module dfu_bank_rd_sched
    import dfu_bank_rd_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    dfu_bank_rd_sched_if.slave bus
);
    dfu_state_e                  state_r;
    dfu_state_e                  next_state_s;
    logic                        load_s;
    logic                        issue_s;
    logic                        busy_s;
    logic                        zero_cfg_s;
    logic                        last_issue_s;
    logic [no_of_sel_ln-1:0]     bank_cnt_s;
    logic [ADDR_W-1:0]           gen_addr_s;
    logic [no_of_sram_banks-1:0] rd_en_s;

    logic [no_of_sram_banks-1:0] sram_rd_en_r;
    logic [ADDR_W-1:0]           sram_rd_addr_r;
    logic [no_of_sel_ln-1:0]     rd_bank_r;
    logic [no_of_sel_ln-1:0]     mux_sel_r;
    logic                        ack_r;
    logic                        busy_r;
    logic                        done_r;

    dfu_rd_addr_gen u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (load_s),
        .adv        (issue_s),
        .base_addr  (bus.cfg_base_addr),
        .num_words  (bus.cfg_num_words),
        .num_banks  (bus.cfg_num_banks),
        .bank_cnt   (bank_cnt_s),
        .rd_addr    (gen_addr_s),
        .last_issue (last_issue_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_r <= IDLE;
        else      state_r <= next_state_s;
    end

    // Next-state decision; an empty window skips straight to completion
    always_comb begin
        zero_cfg_s   = (bus.cfg_num_words == {CNT_W{1'b0}}) ||
                       (bus.cfg_num_banks == {(no_of_sel_ln+1){1'b0}});
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) next_state_s = zero_cfg_s ? DONE : RUN;
                else           next_state_s = IDLE;
            end
            RUN: begin
                if (bus.sys_ready && last_issue_s) next_state_s = DRAIN;
                else                                next_state_s = RUN;
            end
            DRAIN:   next_state_s = DONE;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Per-cycle control decodes feeding the output registers
    always_comb begin
        if (state_r == IDLE && bus.start) load_s = 1'b1;
        else                              load_s = 1'b0;
        if (state_r == RUN && bus.sys_ready) issue_s = 1'b1;
        else                                 issue_s = 1'b0;
        if (issue_s) rd_en_s = onehot_fn(bank_cnt_s);
        else         rd_en_s = {no_of_sram_banks{1'b0}};
        busy_s = (state_r != IDLE) || (next_state_s != IDLE);
    end

    // Output registers; mux select/strobe trail the read they belong to by one cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            sram_rd_en_r   <= {no_of_sram_banks{1'b0}};
            sram_rd_addr_r <= {ADDR_W{1'b0}};
            rd_bank_r      <= {no_of_sel_ln{1'b0}};
            mux_sel_r      <= {no_of_sel_ln{1'b0}};
            ack_r          <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            sram_rd_en_r   <= rd_en_s;
            sram_rd_addr_r <= issue_s ? gen_addr_s : sram_rd_addr_r;
            rd_bank_r      <= issue_s ? bank_cnt_s : rd_bank_r;
            mux_sel_r      <= (|sram_rd_en_r) ? rd_bank_r : mux_sel_r;
            ack_r          <= |sram_rd_en_r;
            busy_r         <= busy_s;
            done_r         <= (state_r == DONE);
        end
    end

    assign bus.sram_rd_en    = sram_rd_en_r;
    assign bus.sram_rd_addr  = sram_rd_addr_r;
    assign bus.mux_sel       = mux_sel_r;
    assign bus.ack_start_sys = ack_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;

endmodule

// File: tb/tb_dfu_bank_rd_sched.sv
// Randomized bench for dfu_bank_rd_sched: per-cycle comparison against a
// sweep-index model, plus fixed expectations for the directed scenarios.
module tb_dfu_bank_rd_sched;
    import dfu_bank_rd_sched_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    dfu_bank_rd_sched_if bus ();

    dfu_bank_rd_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // model: phase 0 idle, 1 run, 2 drain, 3 done; k = reads issued so far
    int                          m_phase = 0;
    int                          m_k     = 0;
    int                          m_total = 0;
    int                          m_nb    = 0;
    logic [ADDR_W-1:0]           m_base  = '0;
    logic [no_of_sram_banks-1:0] e_rd_en = '0;
    logic [ADDR_W-1:0]           e_addr  = '0;
    logic [no_of_sel_ln-1:0]     e_mux   = '0;
    logic [no_of_sel_ln-1:0]     e_bank  = '0;
    logic                        e_ack   = 1'b0;
    logic                        e_busy  = 1'b0;
    logic                        e_done  = 1'b0;

    int                          done_cyc  = -1;
    int                          ack_cnt   = 0;
    int                          busy_cnt  = 0;
    logic [no_of_sel_ln-1:0]     sel_log[$];
    logic [ADDR_W-1:0]           addr_log[$];
    logic [no_of_sram_banks-1:0] en_log[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    task automatic step();
        int  old_phase;
        logic issue;
        int  bank;
        old_phase = m_phase;
        issue     = 1'b0;
        bank      = 0;
        if (!rst) begin
            m_phase = 0; m_k = 0; m_total = 0; m_nb = 0; m_base = '0;
            e_rd_en = '0; e_addr = '0; e_mux = '0; e_bank = '0;
            e_ack = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        end else begin
            e_ack  = (e_rd_en != '0);
            if (e_rd_en != '0) e_mux = e_bank;
            e_done = (m_phase == 3);
            case (m_phase)
                0: if (bus.start) begin
                    m_nb    = int'(bus.cfg_num_banks);
                    m_total = m_nb * int'(bus.cfg_num_words);
                    m_base  = bus.cfg_base_addr;
                    m_k     = 0;
                    m_phase = (m_total == 0) ? 3 : 1;
                end
                1: if (bus.sys_ready) begin
                    issue  = 1'b1;
                    bank   = m_k % m_nb;
                    e_addr = m_base + ADDR_W'(m_k / m_nb);
                    m_k++;
                    if (m_k == m_total) m_phase = 2;
                end
                2:       m_phase = 3;
                default: m_phase = 0;
            endcase
            e_busy  = (old_phase != 0) || (m_phase != 0);
            e_rd_en = issue ? (no_of_sram_banks'(1) << bank) : '0;
            if (issue) e_bank = no_of_sel_ln'(bank);
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("sram_rd_en", 32'(bus.sram_rd_en), 32'(e_rd_en));
        chk("sram_rd_addr", 32'(bus.sram_rd_addr), 32'(e_addr));
        chk("mux_sel", 32'(bus.mux_sel), 32'(e_mux));
        chk("ack_start_sys", 32'(bus.ack_start_sys), 32'(e_ack));
        chk("busy", 32'(bus.busy), 32'(e_busy));
        chk("done", 32'(bus.done), 32'(e_done));
        if (bus.done && done_cyc < 0) done_cyc = cyc;
        if (bus.busy) busy_cnt++;
        if (bus.ack_start_sys) begin
            ack_cnt++;
            sel_log.push_back(bus.mux_sel);
        end
        if (bus.sram_rd_en != '0) begin
            addr_log.push_back(bus.sram_rd_addr);
            en_log.push_back(bus.sram_rd_en);
        end
    endtask

    task automatic clear_logs();
        done_cyc = -1; ack_cnt = 0; busy_cnt = 0;
        sel_log.delete(); addr_log.delete(); en_log.delete();
    endtask

    // one full sweep; stall_after<0 disables the directed stall, rnd randomizes sys_ready
    task automatic sweep(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] nw,
                         input logic [no_of_sel_ln:0] nb, input int stall_after,
                         input int stall_len, input bit rnd, input bit inject, output int lat);
        int start_cyc;
        int stall_left;
        bit stalled;
        clear_logs();
        stalled    = 1'b0;
        stall_left = 0;
        bus.cfg_base_addr = base;
        bus.cfg_num_words = nw;
        bus.cfg_num_banks = nb;
        bus.sys_ready     = 1'b1;
        bus.start         = 1'b1;
        start_cyc         = cyc;
        step();
        for (int i = 0; i < 400; i++) begin
            if (done_cyc >= 0) break;
            if (inject && m_phase != 0 && $urandom_range(0, 2) == 0) begin
                bus.start         = 1'b1;
                bus.cfg_base_addr = ADDR_W'($urandom);
                bus.cfg_num_words = CNT_W'($urandom_range(0, 5));
                bus.cfg_num_banks = (no_of_sel_ln+1)'($urandom_range(0, 8));
            end else begin
                bus.start = 1'b0;
            end
            if (rnd) begin
                bus.sys_ready = ($urandom_range(0, 3) != 0);
            end else if (!stalled && stall_after >= 0 && en_log.size() == stall_after) begin
                stalled    = 1'b1;
                stall_left = stall_len;
            end
            if (!rnd) begin
                bus.sys_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
            end
            step();
        end
        bus.start     = 1'b0;
        bus.sys_ready = 1'b1;
        if (done_cyc < 0) begin
            chk("sweep_timeout", 32'd0, 32'd1);
            lat = -1;
        end else begin
            lat = done_cyc - start_cyc;
        end
    endtask

    task automatic check_seq(input string tag, input int nb, input int n,
                             input logic [ADDR_W-1:0] base);
        chk({tag, "_acks"}, 32'(ack_cnt), 32'(n));
        chk({tag, "_reads"}, 32'(en_log.size()), 32'(n));
        if (en_log.size() == n && sel_log.size() == n) begin
            for (int i = 0; i < n; i++) begin
                chk({tag, "_en"}, 32'(en_log[i]), 32'(1) << (i % nb));
                chk({tag, "_sel"}, 32'(sel_log[i]), 32'(i % nb));
                chk({tag, "_addr"}, 32'(addr_log[i]), 32'(ADDR_W'(base + ADDR_W'(i / nb))));
            end
        end
    endtask

    initial begin
        int lat;
        bus.start = 1'b0;
        bus.cfg_base_addr = '0;
        bus.cfg_num_words = '0;
        bus.cfg_num_banks = '0;
        bus.sys_ready = 1'b0;
        rst = 1'b0;
        step(); step();
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_rd_en", 32'(bus.sram_rd_en), 32'd0);
        rst = 1'b1;
        step();

        // basic sweep with ignored start pulses while busy
        sweep(10'h010, 16'd2, 4'd4, -1, 0, 1'b0, 1'b1, lat);
        chk("basic_lat", 32'(lat), 32'd11);
        chk("basic_busy_cycles", 32'(busy_cnt), 32'd11);
        check_seq("basic", 4, 8, 10'h010);
        step();

        // three-cycle stall after the third read
        sweep(10'h010, 16'd2, 4'd4, 3, 3, 1'b0, 1'b0, lat);
        chk("stall_lat", 32'(lat), 32'd14);
        check_seq("stall", 4, 8, 10'h010);

        // empty windows
        sweep(10'h055, 16'd0, 4'd4, -1, 0, 1'b0, 1'b0, lat);
        chk("zero_words_lat", 32'(lat), 32'd2);
        chk("zero_words_busy", 32'(busy_cnt), 32'd2);
        chk("zero_words_reads", 32'(en_log.size() + ack_cnt), 32'd0);
        sweep(10'h055, 16'd3, 4'd0, -1, 0, 1'b0, 1'b0, lat);
        chk("zero_banks_lat", 32'(lat), 32'd2);
        chk("zero_banks_reads", 32'(en_log.size() + ack_cnt), 32'd0);

        // address wrap
        sweep(10'h3FF, 16'd2, 4'd1, -1, 0, 1'b0, 1'b0, lat);
        chk("wrap_lat", 32'(lat), 32'd5);
        if (addr_log.size() == 2) begin
            chk("wrap_addr0", 32'(addr_log[0]), 32'h3FF);
            chk("wrap_addr1", 32'(addr_log[1]), 32'h000);
        end else begin
            chk("wrap_reads", 32'(addr_log.size()), 32'd2);
        end

        // all eight banks
        sweep(10'h123, 16'd1, 4'd8, -1, 0, 1'b0, 1'b0, lat);
        chk("full_lat", 32'(lat), 32'd11);
        check_seq("full", 8, 8, 10'h123);

        // reset after three reads aborts with no done pulse
        clear_logs();
        bus.cfg_base_addr = 10'h020; bus.cfg_num_words = 16'd2; bus.cfg_num_banks = 4'd4;
        bus.sys_ready = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 20 && en_log.size() < 3; i++) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_rd_en", 32'(bus.sram_rd_en), 32'd0);
        chk("abort_ack", 32'(bus.ack_start_sys), 32'd0);
        done_cyc = -1;
        repeat (5) step();
        chk("abort_no_done", 32'(done_cyc < 0), 32'd1);
        sweep(10'h010, 16'd2, 4'd4, -1, 0, 1'b0, 1'b0, lat);
        chk("after_abort_lat", 32'(lat), 32'd11);
        check_seq("after_abort", 4, 8, 10'h010);

        // randomized sweeps against the model
        for (int r = 0; r < 12; r++) begin
            logic [CNT_W-1:0]      nw;
            logic [no_of_sel_ln:0] nb;
            nw = CNT_W'($urandom_range(0, 4));
            nb = (no_of_sel_ln+1)'($urandom_range(0, 8));
            sweep(ADDR_W'($urandom), nw, nb, -1, 0, 1'b1, 1'b1, lat);
            chk("rand_acks", 32'(ack_cnt), 32'(int'(nw) * int'(nb)));
            repeat ($urandom_range(0, 2)) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dfu_bank_rd_sched.md
Name: dfu_bank_rd_sched

Overview:
- Read scheduler for the data-feed unit (DFU).
- On a start pulse it walks a configured window of SRAM words across the active SRAM banks. For each step it issues one bank read, then one cycle later drives the registered output mux's bank select and its capture strobe (ack_start_sys), so the mux emits one element per step toward the systolic array.
- Sits between the DFU config/start logic and the bank SRAMs plus output mux. It throttles issue on systolic-array backpressure.

Parameters:
- no_of_sram_banks, 8, number of SRAM banks feeding the mux.
- no_of_sel_ln, 3, mux select width; equals clog2(no_of_sram_banks).
- ADDR_W, 10, SRAM word address width.
- CNT_W, 16, word-count width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-low.
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- cfg_base_addr  in  ADDR_W  first word address; captured at accepted start.
- cfg_num_words  in  CNT_W  words per bank to read; captured at start.
- cfg_num_banks  in  no_of_sel_ln+1  active banks 0..N-1 (range 0..no_of_sram_banks); captured at start.
- sys_ready  in  1  systolic side can accept an element next cycle; gates issue.
- sram_rd_en  out  no_of_sram_banks  one-hot bank read enable.
- sram_rd_addr  out  ADDR_W  shared read address.
- mux_sel  out  no_of_sel_ln  bank select to output mux.
- ack_start_sys  out  1  mux capture strobe.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE. All outputs 0, all counters 0, latched cfg 0. Reset mid-sweep aborts immediately; no done pulse.
- States:
  - IDLE: start=1 latches cfg, clears bank_cnt/word_cnt, sets busy=1. If latched num_words==0 or num_banks==0 -> DONE, else -> RUN.
  - RUN: issue cycle when sys_ready=1:
    - sram_rd_en = one-hot(bank_cnt).
    - sram_rd_addr = base_addr + word_cnt, modulo 2^ADDR_W (wrap allowed).
    - Advance bank_cnt. At num_banks-1, bank_cnt wraps to 0 and word_cnt increments.
    - After the issue of (bank num_banks-1, word num_words-1) -> DRAIN.
  - RUN, sys_ready=0: sram_rd_en=0, counters hold.
  - DRAIN: exactly one cycle, to let the last delayed stage fire -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Order: bank-fastest, i.e. (w0,b0),(w0,b1)..(w0,bN-1),(w1,b0)...
- Delay stage, one cycle: ack_start_sys(t+1) = |sram_rd_en(t); mux_sel(t+1) = bank index issued at t.
  - Aligns with 1-cycle SRAM read latency; mux output valid at t+2.
  - The stage fires regardless of sys_ready at t+1; an issued read is never dropped.
  - mux_sel holds its last value when ack_start_sys=0.
- Registered outputs: sram_rd_en, sram_rd_addr, mux_sel, ack_start_sys, busy, done are all registers. Issue reflects sys_ready sampled in the same cycle's comb decision and appears registered on the next edge; sram_rd_addr holds when idle.
- start while busy: ignored, cfg not re-latched.
- start in the same cycle as the DONE state: ignored; must be reasserted in IDLE.
- Total ack_start_sys pulses per sweep = num_words*num_banks. Minimum latency start -> done = num_words*num_banks + 3 cycles with sys_ready held high.

Decomposition:
- Shared dfu package holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - bank-count width function clog2(no_of_sram_banks);
  - address/count width constants.
- One natural sub-module: dfu_rd_addr_gen (bank/word nested counters + address add + last-issue flag).
- FSM and delay stage stay in the top.

Test Plan:
- Basic sweep, banks=4, words=2, base=0x010, sys_ready=1:
  - rd_en 0001,0010,0100,1000,0001,.. with addr 0x010 x4 then 0x011 x4.
  - 8 ack pulses, each one cycle after its rd_en, mux_sel 0,1,2,3,0,1,2,3.
  - done at start+11.
- Backpressure, same cfg, sys_ready=0 for 3 cycles after the 3rd issue:
  - No rd_en during the stall.
  - The 3rd read's ack still fires.
  - Sequence resumes at bank3/word0.
  - Total 8 acks, done delayed by 3.
- Zero config, words=0 (and separately banks=0):
  - No rd_en, no ack.
  - busy for 2 cycles; done one pulse at start+2.
- Address wrap, base=0x3FF, words=2, banks=1: addresses 0x3FF then 0x000.
- Reset and start collisions:
  - rst=0 during RUN after 3 issues: all outputs 0 next cycle, no done, IDLE.
  - A fresh start then sweeps fully.
  - start pulses while busy are ignored.
- Full banks=8, words=1: mux_sel 0..7 with ack; rd_en walks 8 one-hot values.
